// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM read-side helpers: FSM encoding and
// default geometry of the register-file SRAM instances.
package sram_pkg;

   localparam int SRAM_DEPTH_DEF = 16;
   localparam int SRAM_INDEX_DEF = 4;
   localparam int SRAM_WIDTH_DEF = 8;
   localparam int RD_PORTS_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/sram_stream_outreg.sv
// Valid/ready holding register for one output beat: loads on capture,
// drops valid on acceptance without a new capture, clears on abort.
module sram_stream_outreg #(
   parameter int WIDTH = 16,
   parameter int LANES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LANES-1:0] load_mask,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [LANES-1:0] mask
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
         mask  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         mask  <= load_mask;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sram_stream_reader.sv
// Walks a wrapping range of SRAM entries through RD_PORTS read ports and
// streams them as valid/ready beats. SRAM_STREAM_READER_ABORT_EN adds abort_i.
module sram_stream_reader
   import sram_pkg::*;
#(
   parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
   parameter int SRAM_INDEX = $clog2(SRAM_DEPTH),
   parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
   parameter int RD_PORTS   = RD_PORTS_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start_i,
   input  logic [SRAM_INDEX-1:0]          base_i,
   input  logic [SRAM_INDEX:0]            count_i,
`ifdef SRAM_STREAM_READER_ABORT_EN
   input  logic                           abort_i,
`endif
   output logic                           busy_o,
   output logic                           done_o,
   output logic [RD_PORTS*SRAM_INDEX-1:0] rdaddr_o,
   input  logic [RD_PORTS*SRAM_WIDTH-1:0] rddata_i,
   output logic                           out_valid_o,
   output logic [RD_PORTS*SRAM_WIDTH-1:0] out_data_o,
   output logic [RD_PORTS-1:0]            out_mask_o,
   input  logic                           out_ready_i
);

   localparam int CW = SRAM_INDEX + 1;

   state_t                         state_q, state_d;
   logic [SRAM_INDEX-1:0]          ptr_q, ptr_d;
   logic [CW-1:0]                  rem_q, rem_d, rem_step;
   logic                           done_q, done_d;
   logic                           capture, clear, abort;
   logic [RD_PORTS-1:0]            cap_mask;
   logic [RD_PORTS*SRAM_WIDTH-1:0] cap_data;

`ifdef SRAM_STREAM_READER_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   // Lane addresses wrap by plain SRAM_INDEX-bit overflow.
   always_comb begin
      rdaddr_o = '0;
      cap_mask = '0;
      cap_data = '0;
      for (int k = 0; k < RD_PORTS; k++) begin
         rdaddr_o[k*SRAM_INDEX +: SRAM_INDEX] = ptr_q + SRAM_INDEX'(k);
         cap_mask[k] = CW'(k) < rem_q;
         if (cap_mask[k])
            cap_data[k*SRAM_WIDTH +: SRAM_WIDTH] = rddata_i[k*SRAM_WIDTH +: SRAM_WIDTH];
      end
   end

   assign rem_step = (rem_q < CW'(RD_PORTS)) ? rem_q : CW'(RD_PORTS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      capture = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (count_i != '0) begin
                  ptr_d   = base_i;
                  rem_d   = count_i;
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               clear   = 1'b1;
               state_d = IDLE;
            end else if (!out_valid_o || out_ready_i) begin
               capture = 1'b1;
               ptr_d   = ptr_q + SRAM_INDEX'(RD_PORTS);
               rem_d   = rem_q - rem_step;
               if (rem_d == '0)
                  state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               clear   = 1'b1;
               state_d = IDLE;
            end else if (out_valid_o && out_ready_i) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q == RUN) || (state_q == DRAIN);
   assign done_o = done_q;

   sram_stream_outreg #(
      .WIDTH (RD_PORTS*SRAM_WIDTH),
      .LANES (RD_PORTS)
   ) u_outreg (
      .clk       (clk),
      .reset     (reset),
      .load      (capture),
      .clear     (clear),
      .load_data (cap_data),
      .load_mask (cap_mask),
      .ready     (out_ready_i),
      .valid     (out_valid_o),
      .data      (out_data_o),
      .mask      (out_mask_o)
   );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: table of commands with expected
// beats, plus hand-written stall, back-to-back, reset and abort sequences.
module tb_sram_stream_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_i = 1'b0;
   logic [3:0]  base_i = '0;
   logic [4:0]  count_i = '0;
   logic        busy_o, done_o, out_valid_o;
   logic [7:0]  rdaddr_o;
   logic [15:0] rddata_i, out_data_o;
   logic [1:0]  out_mask_o;
   logic        out_ready_i = 1'b1;
`ifdef SRAM_STREAM_READER_ABORT_EN
   logic        abort_i = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]       base;
      logic [4:0]       count;
      int               nbeats;
      logic [3:0][15:0] data;
      logic [3:0][1:0]  mask;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   // SRAM preloaded with entry i = 8'hA0 + i.
   assign rddata_i = {8'hA0 + {4'h0, rdaddr_o[7:4]}, 8'hA0 + {4'h0, rdaddr_o[3:0]}};

   sram_stream_reader dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .base_i      (base_i),
      .count_i     (count_i),
`ifdef SRAM_STREAM_READER_ABORT_EN
      .abort_i     (abort_i),
`endif
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rdaddr_o    (rdaddr_o),
      .rddata_i    (rddata_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_mask_o  (out_mask_o),
      .out_ready_i (out_ready_i)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns at the falling edge of the cycle after start_i was sampled.
   task automatic do_start(input logic [3:0] b, input logic [4:0] c);
      @(posedge clk);
      #1;
      start_i = 1'b1;
      base_i  = b;
      count_i = c;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      @(negedge clk);
   endtask

   // Collects beats at falling edges; returns in the cycle after the last handshake.
   task automatic collect(input int idx, input string tag);
      int nb = 0;
      int cyc = 0;
      while (nb < vecs[idx].nbeats && cyc < 40) begin
         if (out_valid_o && out_ready_i) begin
            check($sformatf("%s data%0d", tag, nb), {16'h0, out_data_o}, {16'h0, vecs[idx].data[nb]});
            check($sformatf("%s mask%0d", tag, nb), {30'h0, out_mask_o}, {30'h0, vecs[idx].mask[nb]});
            nb++;
         end
         if (nb < vecs[idx].nbeats)
            @(negedge clk);
         cyc++;
      end
      check($sformatf("%s beats", tag), nb, vecs[idx].nbeats);
      @(negedge clk);
      check($sformatf("%s done", tag), {31'h0, done_o}, 32'd1);
      check($sformatf("%s busy_end", tag), {31'h0, busy_o}, 32'd0);
      check($sformatf("%s valid_end", tag), {31'h0, out_valid_o}, 32'd0);
   endtask

   initial begin
      logic [3:0] a1;

      vecs[0] = '{base: 4'd0,  count: 5'd4, nbeats: 2,
                  data: {16'h0, 16'h0, 16'hA3A2, 16'hA1A0}, mask: {2'b00, 2'b00, 2'b11, 2'b11}};
      vecs[1] = '{base: 4'd14, count: 5'd4, nbeats: 2,
                  data: {16'h0, 16'h0, 16'hA1A0, 16'hAFAE}, mask: {2'b00, 2'b00, 2'b11, 2'b11}};
      vecs[2] = '{base: 4'd0,  count: 5'd3, nbeats: 2,
                  data: {16'h0, 16'h0, 16'h00A2, 16'hA1A0}, mask: {2'b00, 2'b00, 2'b01, 2'b11}};
      vecs[3] = '{base: 4'd5,  count: 5'd1, nbeats: 1,
                  data: {16'h0, 16'h0, 16'h0, 16'h00A5}, mask: {2'b00, 2'b00, 2'b00, 2'b01}};
      vecs[4] = '{base: 4'd15, count: 5'd3, nbeats: 2,
                  data: {16'h0, 16'h0, 16'h00A1, 16'hA0AF}, mask: {2'b00, 2'b00, 2'b01, 2'b11}};
      vecs[5] = '{base: 4'd9,  count: 5'd5, nbeats: 3,
                  data: {16'h0, 16'h00AD, 16'hACAB, 16'hAAA9}, mask: {2'b00, 2'b01, 2'b11, 2'b11}};
      vecs[6] = '{base: 4'd0,  count: 5'd6, nbeats: 3,
                  data: {16'h0, 16'hA5A4, 16'hA3A2, 16'hA1A0}, mask: {2'b00, 2'b11, 2'b11, 2'b11}};

      // Reset state.
      #12;
      check("rst valid", {31'h0, out_valid_o}, 32'd0);
      check("rst busy", {31'h0, busy_o}, 32'd0);
      check("rst done", {31'h0, done_o}, 32'd0);
      check("rst data", {16'h0, out_data_o}, 32'h0);
      check("rst mask", {30'h0, out_mask_o}, 32'h0);
      check("rst rdaddr", {24'h0, rdaddr_o}, 32'h10);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Table-driven commands at full throughput.
      for (int i = 0; i < 7; i++) begin
         do_start(vecs[i].base, vecs[i].count);
         a1 = vecs[i].base + 4'd1;
         check($sformatf("v%0d busy", i), {31'h0, busy_o}, 32'd1);
         check($sformatf("v%0d first_valid", i), {31'h0, out_valid_o}, 32'd0);
         check($sformatf("v%0d rdaddr", i), {24'h0, rdaddr_o}, {24'h0, a1, vecs[i].base});
         collect(i, $sformatf("v%0d", i));
         @(negedge clk);
         check($sformatf("v%0d done_pulse", i), {31'h0, done_o}, 32'd0);
      end

      // Back-to-back: start issued in the done cycle is accepted.
      do_start(4'd0, 5'd4);
      collect(0, "b2b_a");
      start_i = 1'b1;
      base_i  = 4'd14;
      count_i = 5'd4;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      @(negedge clk);
      check("b2b busy", {31'h0, busy_o}, 32'd1);
      collect(1, "b2b_b");

      // Consumer stall on the first beat.
      out_ready_i = 1'b0;
      do_start(4'd0, 5'd6);
      @(negedge clk);
      check("stall valid", {31'h0, out_valid_o}, 32'd1);
      check("stall data", {16'h0, out_data_o}, 32'hA1A0);
      check("stall rdaddr", {24'h0, rdaddr_o}, 32'h32);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("stall%0d valid", c), {31'h0, out_valid_o}, 32'd1);
         check($sformatf("stall%0d data", c), {16'h0, out_data_o}, 32'hA1A0);
         check($sformatf("stall%0d mask", c), {30'h0, out_mask_o}, 32'h3);
         check($sformatf("stall%0d rdaddr", c), {24'h0, rdaddr_o}, 32'h32);
      end
      out_ready_i = 1'b1;
      collect(6, "stall");

      // Zero-length command.
      do_start(4'd3, 5'd0);
      check("zero done", {31'h0, done_o}, 32'd1);
      check("zero busy", {31'h0, busy_o}, 32'd0);
      check("zero valid", {31'h0, out_valid_o}, 32'd0);
      @(negedge clk);
      check("zero done_low", {31'h0, done_o}, 32'd0);
      check("zero valid_low", {31'h0, out_valid_o}, 32'd0);

      // Start while busy is ignored.
      do_start(4'd0, 5'd4);
      start_i = 1'b1;
      base_i  = 4'd8;
      count_i = 5'd2;
      @(negedge clk);
      start_i = 1'b0;
      collect(0, "ign");
      @(negedge clk);
      check("ign valid1", {31'h0, out_valid_o}, 32'd0);
      check("ign busy1", {31'h0, busy_o}, 32'd0);
      @(negedge clk);
      check("ign valid2", {31'h0, out_valid_o}, 32'd0);

      // Reset asserted while in DRAIN.
      out_ready_i = 1'b0;
      do_start(4'd0, 5'd2);
      @(negedge clk);
      check("drain busy", {31'h0, busy_o}, 32'd1);
      check("drain valid", {31'h0, out_valid_o}, 32'd1);
      reset = 1'b0;
      #1;
      check("rstd valid", {31'h0, out_valid_o}, 32'd0);
      check("rstd busy", {31'h0, busy_o}, 32'd0);
      check("rstd done", {31'h0, done_o}, 32'd0);
      check("rstd data", {16'h0, out_data_o}, 32'h0);
      check("rstd mask", {30'h0, out_mask_o}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk);
      check("rstd done1", {31'h0, done_o}, 32'd0);
      @(negedge clk);
      check("rstd done2", {31'h0, done_o}, 32'd0);
      do_start(4'd14, 5'd4);
      collect(1, "post_rst");

`ifdef SRAM_STREAM_READER_ABORT_EN
      // Abort while stalled in RUN.
      out_ready_i = 1'b0;
      do_start(4'd0, 5'd8);
      @(negedge clk);
      check("abort pre_valid", {31'h0, out_valid_o}, 32'd1);
      abort_i = 1'b1;
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      check("abort valid", {31'h0, out_valid_o}, 32'd0);
      check("abort busy", {31'h0, busy_o}, 32'd0);
      @(negedge clk);
      check("abort done", {31'h0, done_o}, 32'd0);
      out_ready_i = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
